// File: rtl/rx_frame_arbiter_pkg.sv
// rtl/rx_frame_arbiter_pkg.sv - shared switch-wide defines for the RX frame arbiter
// Purpose: FSM state encodings, default frame limit and RX FIFO entry layout.
// Ports: none (package).
package rx_frame_arbiter_pkg;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_XFER  = 2'b01;
  localparam logic [1:0] S_DRAIN = 2'b10;

  localparam int MAX_LEN_DEF  = 1518;
  localparam int FIFO_ENTRY_W = 9;

  // One RX FIFO entry as written by the SNI receive front-end.
  typedef struct packed {
    logic       eod;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/rx_frame_arbiter_if.sv
// rtl/rx_frame_arbiter_if.sv - RX FIFO read side plus downstream byte stream bundle
// Purpose: groups the per-port FIFO head/pop signals and the forwarded byte stream.
// Ports (signals):
//   fifo_empty/fifo_dout/fifo_EOD_out : per-port FIFO heads (first-word-fall-through)
//   fifo_rden                         : per-port pop strobes
//   out_data/out_valid/out_eod/out_err/out_ready/out_port : downstream byte stream
// Modports: master = arbiter side, slave = FIFOs + downstream side.
interface rx_frame_arbiter_if #(
  parameter int NPORT = 4
) ();
  localparam int PW = $clog2(NPORT);

  logic [NPORT-1:0]   fifo_empty;
  logic [8*NPORT-1:0] fifo_dout;
  logic [NPORT-1:0]   fifo_EOD_out;
  logic [NPORT-1:0]   fifo_rden;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_eod;
  logic               out_err;
  logic               out_ready;
  logic [PW-1:0]      out_port;

  modport master (
    input  fifo_empty, fifo_dout, fifo_EOD_out, out_ready,
    output fifo_rden, out_data, out_valid, out_eod, out_err, out_port
  );

  modport slave (
    output fifo_empty, fifo_dout, fifo_EOD_out, out_ready,
    input  fifo_rden, out_data, out_valid, out_eod, out_err, out_port
  );
endinterface

// File: rtl/rx_frame_arbiter_rr_pick.sv
// rtl/rx_frame_arbiter_rr_pick.sv - combinational round-robin selector
// Purpose: picks the first requesting index strictly after 'last', modulo NPORT.
// Ports:
//   req     in  NPORT  request vector
//   last    in  PW     index granted most recently
//   gnt_idx out PW     selected index (0 when nothing requests)
//   any     out 1      at least one request present
module rr_pick #(
  parameter int NPORT = 4,
  parameter int PW    = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    last,
  output logic [PW-1:0]    gnt_idx,
  output logic             any
);

  // Scan from the farthest candidate back to the nearest so the nearest
  // requester after 'last' is the one that sticks.
  always_comb begin
    int j;
    gnt_idx = '0;
    for (int k = NPORT; k >= 1; k--) begin
      j = (int'(last) + k) % NPORT;
      if (req[PW'(j)]) gnt_idx = PW'(j);
    end
  end

  assign any = |req;

endmodule

// File: rtl/rx_frame_arbiter.sv
// rtl/rx_frame_arbiter.sv - frame-atomic round-robin scheduler over NPORT RX FIFOs
// Purpose: grants one port at a time, forwards whole frames through to the EOD
// byte, and truncates then drains frames longer than MAX_LEN.
// Ports:
//   clk      in  1      user-domain clock
//   arst_n   in  1      asynchronous active-low reset
//   port_en  in  NPORT  per-port grant enable
//   bus      master     FIFO heads/pops and downstream byte stream
//   drop_cnt out 16     saturating count of truncated frames
module rx_frame_arbiter
  import rx_frame_arbiter_pkg::*;
#(
  parameter int NPORT   = 4,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LW      = 11
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic [NPORT-1:0]   port_en,
  rx_frame_arbiter_if.master bus,
  output logic [15:0]        drop_cnt
);
  localparam int PW = $clog2(NPORT);

  logic [1:0]       r_state;
  logic [PW-1:0]    r_grant;
  logic [PW-1:0]    r_last_grant;
  logic [LW-1:0]    r_byte_cnt;
  logic [15:0]      r_drop_cnt;

  logic [NPORT-1:0] w_req;
  logic [PW-1:0]    w_pick;
  logic             w_any;
  logic             w_head_empty;
  logic             w_head_eod;
  logic [7:0]       w_head_data;
  logic             w_xfer;
  logic             w_drain;
  logic             w_trunc;
  logic             w_valid;
  logic             w_fire;
  logic             w_err;

  assign w_req = port_en & ~bus.fifo_empty;

  rr_pick #(.NPORT(NPORT), .PW(PW)) u_rr_pick (
    .req     (w_req),
    .last    (r_last_grant),
    .gnt_idx (w_pick),
    .any     (w_any)
  );

  // Head of the granted FIFO; the byte path stays combinational.
  assign w_head_empty = bus.fifo_empty[r_grant];
  assign w_head_eod   = bus.fifo_EOD_out[r_grant];
  assign w_head_data  = bus.fifo_dout[{r_grant, 3'b000} +: 8];

  assign w_xfer  = (r_state == S_XFER);
  assign w_drain = (r_state == S_DRAIN);
  assign w_trunc = (r_byte_cnt == LW'(MAX_LEN - 1));
  assign w_valid = w_xfer & ~w_head_empty;
  assign w_fire  = w_valid & bus.out_ready;
  // EOD landing exactly on the limit byte is a normal end, not an error.
  assign w_err   = w_trunc & ~w_head_eod;

  // Stream outputs are forced low outside S_XFER so idle/reset show all zeros.
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_xfer ? w_head_data : 8'h00;
  assign bus.out_eod   = w_xfer & (w_head_eod | w_trunc);
  assign bus.out_err   = w_xfer & w_err;
  assign bus.out_port  = r_grant;
  assign drop_cnt      = r_drop_cnt;

  // Draining pops the remainder of a runaway frame regardless of out_ready.
  always_comb begin
    bus.fifo_rden = '0;
    if (w_fire || (w_drain && !w_head_empty)) bus.fifo_rden[r_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= PW'(NPORT - 1);
      r_byte_cnt   <= '0;
      r_drop_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant    <= w_pick;
            r_byte_cnt <= '0;
            r_state    <= S_XFER;
          end
        end
        S_XFER: begin
          if (w_fire) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (w_head_eod) begin
              r_last_grant <= r_grant;
              r_state      <= S_IDLE;
            end else if (w_trunc) begin
              if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!w_head_empty && w_head_eod) begin
            r_last_grant <= r_grant;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_arbiter.sv
// tb/tb_rx_frame_arbiter.sv - directed self-checking bench for rx_frame_arbiter
module tb_rx_frame_arbiter;
  localparam int NP = 4;
  localparam int ML = 1518;

  logic          clk = 1'b0;
  logic          arst_n;
  logic [NP-1:0] port_en;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  rx_frame_arbiter_if #(.NPORT(NP)) bus ();

  rx_frame_arbiter #(.NPORT(NP), .MAX_LEN(ML), .LW(11)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .port_en  (port_en),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );

  // FIFO model: written by the stimulus, popped by the monitor.
  logic [8:0]  mem [NP][4096];
  int          wp [NP];
  int          rp [NP];
  int          pop_cnt [NP];
  int          drain_cnt [NP];
  logic [11:0] lg_beat [4096];
  int          lg_cyc [4096];
  int          log_n = 0;
  int          cyc = 0;
  int          rden_bad = 0;
  int          fifo_clr_seq = 0, fifo_clr_seen = 0;
  int          log_clr_seq = 0, log_clr_seen = 0;

  int          n_vec = 0;
  int          n_err = 0;

  int          e_port [8];
  int          e_len [8];
  int          e_base [8];
  bit          e_trunc [8];
  int          ne = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    for (int p = 0; p < NP; p++) begin
      bus.fifo_empty[p]       = (rp[p] >= wp[p]);
      bus.fifo_dout[8*p +: 8] = mem[p][rp[p] % 4096][7:0];
      bus.fifo_EOD_out[p]     = mem[p][rp[p] % 4096][8];
    end
  endtask

  always @(posedge clk) begin
    if (fifo_clr_seen != fifo_clr_seq) begin
      fifo_clr_seen = fifo_clr_seq;
      for (int p = 0; p < NP; p++) begin
        rp[p] = 0; pop_cnt[p] = 0; drain_cnt[p] = 0;
      end
    end
    if (log_clr_seen != log_clr_seq) begin
      log_clr_seen = log_clr_seq;
      log_n = 0;
      rden_bad = 0;
    end
    if (arst_n) begin
      if (bus.out_valid) begin
        if (bus.fifo_rden !== (bus.out_ready ? (4'b0001 << bus.out_port) : 4'b0000)) rden_bad++;
        if (bus.out_ready && log_n < 4096) begin
          lg_beat[log_n] = {bus.out_port, bus.out_eod, bus.out_err, bus.out_data};
          lg_cyc[log_n]  = cyc;
          log_n++;
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (bus.fifo_rden[p] && rp[p] < wp[p]) begin
          rp[p]++;
          pop_cnt[p]++;
          if (!bus.out_valid) drain_cnt[p]++;
        end
      end
    end
    cyc++;
    #1;
    refresh();
  end

  task automatic push_frame(input int p, input int len, input int base, input bit eod);
    for (int i = 0; i < len; i++) begin
      mem[p][wp[p]] = {eod && (i == len - 1), 8'(base + i)};
      wp[p]++;
    end
  endtask

  task automatic add_exp(input int p, input int len, input int base, input bit trunc);
    e_port[ne] = p; e_len[ne] = len; e_base[ne] = base; e_trunc[ne] = trunc;
    ne++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n = 1'b0;
    for (int p = 0; p < NP; p++) wp[p] = 0;
    fifo_clr_seq++;
    log_clr_seq++;
    ne = 0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (log_n < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (log_n < n) chk({tag, "_timeout"}, log_n, n);
  endtask

  task automatic check_frames(input string tag, input bit gap_chk);
    int k, total;
    logic [7:0]  b;
    logic [11:0] exp;
    bit lst;
    total = 0;
    for (int f = 0; f < ne; f++) total += e_len[f];
    chk({tag, "_nbeats"}, log_n, total);
    k = 0;
    for (int f = 0; f < ne; f++) begin
      for (int i = 0; i < e_len[f]; i++) begin
        if (k < log_n) begin
          b   = 8'(e_base[f] + i);
          lst = (i == e_len[f] - 1);
          exp = {2'(e_port[f]), lst, e_trunc[f] & lst, b};
          chk({tag, "_beat"}, lg_beat[k], exp);
          if (gap_chk && k > 0) chk({tag, "_gap"}, lg_cyc[k] - lg_cyc[k-1], (i == 0) ? 2 : 1);
        end
        k++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gap_at, c;
    arst_n = 1'b0;
    port_en = '1;
    bus.out_ready = 1'b1;
    for (int p = 0; p < NP; p++) wp[p] = 0;
    repeat (3) @(negedge clk);
    chk("reset_out", {bus.out_valid, bus.out_eod, bus.out_err, bus.out_data, bus.fifo_rden, bus.out_port}, 0);
    chk("reset_drop", drop_cnt, 0);
    arst_n = 1'b1;

    // Single 64-byte frame on port 1.
    ne = 0;
    add_exp(1, 64, 'h40, 0);
    @(negedge clk);
    push_frame(1, 64, 'h40, 1);
    @(negedge clk);
    chk("t1_idle_before_grant", bus.out_valid, 0);
    @(negedge clk);
    chk("t1_grant_port", bus.out_port, 1);
    chk("t1_valid", bus.out_valid, 1);
    wait_beats(64, 200, "t1");
    repeat (3) @(negedge clk);
    check_frames("t1", 1);
    chk("t1_idle_after", bus.out_valid, 0);
    chk("t1_pops", pop_cnt[1], 64);
    chk("t1_rden", rden_bad, 0);

    // Ports 0,2,3 with two frames each: strict rotation, one idle cycle between frames.
    do_reset();
    push_frame(0, 3, 'h00, 1); push_frame(0, 2, 'h08, 1);
    push_frame(2, 5, 'h20, 1); push_frame(2, 6, 'h28, 1);
    push_frame(3, 4, 'h30, 1); push_frame(3, 1, 'h38, 1);
    add_exp(0, 3, 'h00, 0); add_exp(2, 5, 'h20, 0); add_exp(3, 4, 'h30, 0);
    add_exp(0, 2, 'h08, 0); add_exp(2, 6, 'h28, 0); add_exp(3, 1, 'h38, 0);
    wait_beats(21, 200, "t2");
    repeat (4) @(negedge clk);
    check_frames("t2", 1);
    chk("t2_rden", rden_bad, 0);

    // Runaway frame truncated at MAX_LEN, then a normal frame, then EOD exactly on the limit.
    do_reset();
    port_en = 4'b0001;
    push_frame(0, 1600, 'h00, 1);
    push_frame(0, 10, 'hA0, 1);
    push_frame(0, ML, 'h33, 1);
    add_exp(0, ML, 'h00, 1); add_exp(0, 10, 'hA0, 0); add_exp(0, ML, 'h33, 0);
    wait_beats(2 * ML + 10, 4000, "t3");
    repeat (5) @(negedge clk);
    check_frames("t3", 0);
    chk("t3_drop", drop_cnt, 1);
    chk("t3_drain", drain_cnt[0], 82);
    chk("t3_pops", pop_cnt[0], 1600 + 10 + ML);
    chk("t3_rden", rden_bad, 0);

    // Backpressure pattern 1,0,0,1 plus a FIFO underrun mid-frame on port 3.
    log_clr_seq++;
    ne = 0;
    port_en = '1;
    add_exp(3, 20, 'h50, 0);
    push_frame(3, 8, 'h50, 0);
    gap_at = -1;
    for (int cc = 0; cc < 200; cc++) begin
      @(negedge clk);
      bus.out_ready = (cc % 4 == 0) || (cc % 4 == 3);
      if (gap_at < 0 && pop_cnt[3] == 8) gap_at = cc;
      if (gap_at >= 0 && cc > gap_at && cc <= gap_at + 5) begin
        chk("t4_gap_port", bus.out_port, 3);
        chk("t4_gap_valid", bus.out_valid, 0);
      end
      if (gap_at >= 0 && cc == gap_at + 5) push_frame(3, 12, 'h58, 1);
    end
    bus.out_ready = 1'b1;
    check_frames("t4", 0);
    chk("t4_pops", pop_cnt[3], 20);
    chk("t4_drop_kept", drop_cnt, 1);
    chk("t4_rden", rden_bad, 0);

    // Port mask: port 2 masked, port 0 disabled mid-frame.
    port_en = 4'b1011;
    do_reset();
    push_frame(0, 6, 'h60, 1); push_frame(0, 3, 'h68, 1);
    push_frame(1, 4, 'h70, 1); push_frame(1, 2, 'h78, 1);
    push_frame(2, 5, 'h80, 1);
    push_frame(3, 3, 'h90, 1); push_frame(3, 2, 'h98, 1);
    add_exp(0, 6, 'h60, 0); add_exp(1, 4, 'h70, 0); add_exp(3, 3, 'h90, 0);
    add_exp(1, 2, 'h78, 0); add_exp(3, 2, 'h98, 0);
    c = 0;
    while (log_n < 2 && c < 50) begin
      @(negedge clk);
      c++;
    end
    port_en = 4'b1010;
    wait_beats(17, 300, "t5");
    repeat (5) @(negedge clk);
    check_frames("t5", 1);
    chk("t5_port2_pops", pop_cnt[2], 0);
    chk("t5_port0_pops", pop_cnt[0], 6);
    chk("t5_rden", rden_bad, 0);

    // Reset pulse in the middle of a port 2 frame.
    port_en = '1;
    do_reset();
    push_frame(2, 20, 'hB0, 1);
    wait_beats(5, 50, "t6a");
    arst_n = 1'b0;
    #1;
    chk("t6_rst_out", {bus.out_valid, bus.out_eod, bus.out_err, bus.out_data, bus.fifo_rden, bus.out_port}, 0);
    log_clr_seq++;
    ne = 0;
    push_frame(1, 4, 'hC0, 1);
    add_exp(1, 4, 'hC0, 0);
    add_exp(2, 15, 'hB5, 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk("t6_first_grant", bus.out_port, 1);
    chk("t6_first_valid", bus.out_valid, 1);
    wait_beats(19, 200, "t6");
    repeat (5) @(negedge clk);
    check_frames("t6", 1);
    chk("t6_rden", rden_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
